// File: rtl/serial_io_cond.sv
// Board-level serial I/O conditioning between FPGA pads and core_top:
// registered TX drivers, synchronised and glitch-filtered RX, loopback, activity LEDs.
module serial_io_cond #(
    parameter int N_CH        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int LED_HOLD    = 3_000_000
) (
    input  logic            sysclk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_pad_rx,
    output logic [N_CH-1:0] o_pad_tx,
    input  logic [N_CH-1:0] i_core_tx,
    output logic [N_CH-1:0] o_core_rx,
    input  logic [N_CH-1:0] i_loopback,
    output logic            o_rst_n_sync,
    output logic            o_rst_led,
    output logic [N_CH-1:0] o_tx_led,
    output logic [N_CH-1:0] o_rx_led
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int LCW = $clog2(LED_HOLD + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [LCW-1:0] LED_LOAD  = LCW'(LED_HOLD);

    logic            r_rst_meta;
    logic            r_rst_sync;
    logic [N_CH-1:0] r_tx_mon;
    logic [N_CH-1:0] r_pad_tx;
    logic [N_CH-1:0] r_core_rx;
    logic [N_CH-1:0] r_rx_sync [SYNC_STAGES];
    logic [N_CH-1:0] w_rx_sync;
    logic [N_CH-1:0] w_rx_filt;

    // Reset synchroniser: asserts with i_rst_n, releases two edges later.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign o_rst_n_sync = r_rst_sync;
    assign o_rst_led    = r_rst_sync;

    // Pad driver is forced idle-high while the channel is looped back.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_mon <= '1;
            r_pad_tx <= '1;
        end else begin
            r_tx_mon <= i_core_tx;
            r_pad_tx <= i_core_tx | i_loopback;
        end
    end

    assign o_pad_tx = r_pad_tx;

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_rx_sync[s] <= '1;
            end
        end else begin
            r_rx_sync[0] <= i_pad_rx;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_rx_sync[s] <= r_rx_sync[s-1];
            end
        end
    end

    assign w_rx_sync = r_rx_sync[SYNC_STAGES-1];

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_core_rx <= '1;
        end else begin
            r_core_rx <= (i_loopback & i_core_tx) | (~i_loopback & w_rx_filt);
        end
    end

    assign o_core_rx = r_core_rx;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic           r_filt;
        logic [FCW-1:0] r_filt_cnt;
        logic [LCW-1:0] r_tx_led_cnt;
        logic [LCW-1:0] r_rx_led_cnt;

        // A new level is accepted only after persisting FILTER_LEN cycles.
        always_ff @(posedge sysclk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_filt     <= 1'b1;
                r_filt_cnt <= '0;
            end else if (w_rx_sync[c] == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_filt     <= w_rx_sync[c];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end

        assign w_rx_filt[c] = r_filt;

        always_ff @(posedge sysclk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_tx_led_cnt <= '0;
                r_rx_led_cnt <= '0;
            end else begin
                if (!r_tx_mon[c]) begin
                    r_tx_led_cnt <= LED_LOAD;
                end else if (r_tx_led_cnt != '0) begin
                    r_tx_led_cnt <= r_tx_led_cnt - 1'b1;
                end
                if (!r_core_rx[c]) begin
                    r_rx_led_cnt <= LED_LOAD;
                end else if (r_rx_led_cnt != '0) begin
                    r_rx_led_cnt <= r_rx_led_cnt - 1'b1;
                end
            end
        end

        assign o_tx_led[c] = (r_tx_led_cnt != '0);
        assign o_rx_led[c] = (r_rx_led_cnt != '0);
    end

endmodule

// File: tb/tb_serial_io_cond.sv
// Self-checking bench for serial_io_cond: per-scenario tasks with a queue of
// expected output vectors {pad_tx, core_rx, tx_led, rx_led} popped every edge.
module tb_serial_io_cond;

    localparam int N_CH        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
    localparam int LED_HOLD    = 8;

    logic       sysclk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_pad_rx;
    logic [1:0] o_pad_tx;
    logic [1:0] i_core_tx;
    logic [1:0] o_core_rx;
    logic [1:0] i_loopback;
    logic       o_rst_n_sync;
    logic       o_rst_led;
    logic [1:0] o_tx_led;
    logic [1:0] o_rx_led;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q [$];
    logic [7:0] w_obs;

    assign w_obs = {o_pad_tx, o_core_rx, o_tx_led, o_rx_led};

    always #5 sysclk = ~sysclk;

    serial_io_cond #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .LED_HOLD    (LED_HOLD)
    ) u_dut (
        .sysclk       (sysclk),
        .i_rst_n      (i_rst_n),
        .i_pad_rx     (i_pad_rx),
        .o_pad_tx     (o_pad_tx),
        .i_core_tx    (i_core_tx),
        .o_core_rx    (o_core_rx),
        .i_loopback   (i_loopback),
        .o_rst_n_sync (o_rst_n_sync),
        .o_rst_led    (o_rst_led),
        .o_tx_led     (o_tx_led),
        .o_rx_led     (o_rx_led)
    );

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_pad_rx   = 2'($urandom_range(0, 3));
            i_core_tx  = 2'($urandom_range(0, 3));
            i_loopback = 2'($urandom_range(0, 3));
            tick();
            n_total++;
            if (w_obs !== 8'b1111_0000) $display("FAIL reset_outputs k=%0d got %b want %b", k, w_obs, 8'b1111_0000);
            else n_pass++;
            n_total++;
            if ({o_rst_n_sync, o_rst_led} !== 2'b00) $display("FAIL reset_sync_held k=%0d got %b want 00", k, {o_rst_n_sync, o_rst_led});
            else n_pass++;
        end
        i_pad_rx   = 2'b11;
        i_core_tx  = 2'b11;
        i_loopback = 2'b00;
        tick();
        #2 i_rst_n = 1'b1;
        tick();
        n_total++;
        if ({o_rst_n_sync, o_rst_led} !== 2'b00) $display("FAIL reset_release_edge1 got %b want 00", {o_rst_n_sync, o_rst_led});
        else n_pass++;
        tick();
        n_total++;
        if ({o_rst_n_sync, o_rst_led} !== 2'b11) $display("FAIL reset_release_edge2 got %b want 11", {o_rst_n_sync, o_rst_led});
        else n_pass++;
        repeat (12) tick();
        n_total++;
        if (w_obs !== 8'b1111_0000) $display("FAIL reset_idle got %b want %b", w_obs, 8'b1111_0000);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [7:0] exp_v;
        logic       c0, l0;
        for (int k = 1; k <= 20; k++) begin
            i_pad_rx[0] = (k <= 3) ? 1'b0 : 1'b1;
            exp_q.push_back(8'b1111_0000);
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL glitch_short k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
        end
        for (int k = 1; k <= 26; k++) begin
            i_pad_rx[0] = (k <= 6) ? 1'b0 : 1'b1;
            c0 = (k >= 7 && k <= 12) ? 1'b0 : 1'b1;
            l0 = (k >= 8 && k <= 20) ? 1'b1 : 1'b0;
            exp_q.push_back({2'b11, 1'b1, c0, 2'b00, 1'b0, l0});
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL glitch_long k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_tx_led();
        logic [7:0] exp_v;
        logic [1:0] p, t;
        for (int k = 1; k <= 12; k++) begin
            i_core_tx[1] = (k == 1) ? 1'b0 : 1'b1;
            p = (k == 1) ? 2'b01 : 2'b11;
            t = (k >= 2 && k <= 9) ? 2'b10 : 2'b00;
            exp_q.push_back({p, 2'b11, t, 2'b00});
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL tx_led k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_v;
        logic [9:0] frame;
        logic       c0;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 1; k <= 40; k++) begin
            i_loopback[0] = (k <= 25) ? 1'b1 : 1'b0;
            if (k >= 2 && k <= 11) begin
                i_core_tx[0] = frame[k-2];
                i_pad_rx[0]  = 1'($urandom_range(0, 1));
            end else begin
                i_core_tx[0] = 1'b1;
                i_pad_rx[0]  = (k >= 12 && k <= 26) ? 1'b0 : 1'b1;
            end
            if (k >= 2 && k <= 11) c0 = frame[k-2];
            else if (k >= 26 && k <= 32) c0 = 1'b0;
            else c0 = 1'b1;
            exp_q.push_back({2'b11, 1'b1, c0, 4'b0000});
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs[7:4] !== exp_v[7:4]) $display("FAIL loopback k=%0d got %b want %b", k, w_obs[7:4], exp_v[7:4]);
            else n_pass++;
        end
        repeat (12) tick();
        n_total++;
        if (w_obs !== 8'b1111_0000) $display("FAIL loopback_idle got %b want %b", w_obs, 8'b1111_0000);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_v;
        logic       c0, l0;
        for (int k = 1; k <= 16; k++) begin
            i_pad_rx[0] = (k <= 12) ? 1'b0 : 1'b1;
            c0 = (k >= 7) ? 1'b0 : 1'b1;
            l0 = (k >= 8) ? 1'b1 : 1'b0;
            exp_q.push_back({2'b11, 1'b1, c0, 2'b00, 1'b0, l0});
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL reset_mid_pre k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_total++;
        if (w_obs !== 8'b1111_0000) $display("FAIL reset_mid_async got %b want %b", w_obs, 8'b1111_0000);
        else n_pass++;
        n_total++;
        if ({o_rst_n_sync, o_rst_led} !== 2'b00) $display("FAIL reset_mid_sync got %b want 00", {o_rst_n_sync, o_rst_led});
        else n_pass++;
        tick();
        tick();
        #2 i_rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back(8'b1111_0000);
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL reset_mid_post k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
            if (k <= 2) begin
                n_total++;
                if (o_rst_n_sync !== (k == 2)) $display("FAIL reset_mid_release k=%0d got %b want %b", k, o_rst_n_sync, (k == 2));
                else n_pass++;
            end
        end
    endtask

    task automatic test_sustained();
        logic [7:0] exp_v;
        logic       c1, l1;
        for (int k = 1; k <= 70; k++) begin
            i_pad_rx[1] = (k <= 50) ? 1'b0 : 1'b1;
            c1 = (k >= 7 && k <= 56) ? 1'b0 : 1'b1;
            l1 = (k >= 8 && k <= 64) ? 1'b1 : 1'b0;
            exp_q.push_back({2'b11, c1, 1'b1, 2'b00, l1, 1'b0});
            tick();
            exp_v = exp_q.pop_front();
            n_total++;
            if (w_obs !== exp_v) $display("FAIL sustained k=%0d got %b want %b", k, w_obs, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_pad_rx   = 2'b11;
        i_core_tx  = 2'b11;
        i_loopback = 2'b00;
        test_reset();
        test_glitch();
        test_tx_led();
        test_loopback();
        test_reset_mid();
        test_sustained();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
